// File: rtl/rtc_bus_arbiter.sv
// Arbitrates four RTC requesters onto one bus transaction sequencer, with fixed priority,
// lockable bursts bounded by MAX_LOCK, a per-transaction timeout and an enforced bus gap.
module rtc_bus_arbiter #(
  parameter int unsigned TIMEOUT    = 127,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned MAX_LOCK   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  lock,
  input  logic [3:0]  we,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic [7:0]  rdata,
  output logic        txn_start,
  output logic        txn_rd,
  output logic [7:0]  txn_addr,
  output logic [7:0]  txn_data,
  input  logic        txn_done,
  input  logic [7:0]  txn_rdata,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam int unsigned LockW = $clog2(MAX_LOCK + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       own_q;
  logic             lock_vld_q;
  logic [LockW-1:0] lock_cnt_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic [3:0]       gap_cnt_q;

  logic [3:0] own_mask;
  logic [3:0] req_m;
  logic       lock_hit;
  logic [1:0] win;

  // lock_cnt_q counts grants in the current locked chain, so the first grant sets it to 1.
  always_comb begin
    own_mask = 4'b0001 << own_q;
    lock_hit = lock_vld_q && req[own_q] && (lock_cnt_q < LockW'(MAX_LOCK));
    req_m    = req;
    if (lock_vld_q && !lock_hit && (lock_cnt_q >= LockW'(MAX_LOCK)) && |(req & ~own_mask)) begin
      req_m = req & ~own_mask;
    end
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_m[i]) win = 2'(i);
    end
    if (lock_hit) win = own_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      own_q       <= 2'd0;
      lock_vld_q  <= 1'b0;
      lock_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      gap_cnt_q   <= 4'd0;
      gnt         <= 4'd0;
      ack         <= 4'd0;
      rdata       <= 8'd0;
      txn_start   <= 1'b0;
      txn_rd      <= 1'b1;
      txn_addr    <= 8'd0;
      txn_data    <= 8'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      txn_start   <= 1'b0;
      ack         <= 4'd0;
      timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q    <= StWait;
            busy       <= 1'b1;
            own_q      <= win;
            gnt        <= 4'b0001 << win;
            txn_start  <= 1'b1;
            txn_rd     <= ~we[win];
            txn_addr   <= addr_in[{win, 3'b000} +: 8];
            txn_data   <= data_in[{win, 3'b000} +: 8];
            wait_cnt_q <= '0;
            lock_cnt_q <= lock_hit ? lock_cnt_q + LockW'(1) : LockW'(1);
          end
        end
        StWait: begin
          if (txn_done) begin
            ack        <= 4'b0001 << own_q;
            if (txn_rd) rdata <= txn_rdata;
            lock_vld_q <= lock[own_q];
            if (!lock[own_q]) lock_cnt_q <= '0;
            gnt        <= 4'd0;
            gap_cnt_q  <= 4'd0;
            state_q    <= StGap;
          end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            lock_vld_q  <= 1'b0;
            lock_cnt_q  <= '0;
            gnt         <= 4'd0;
            gap_cnt_q   <= 4'd0;
            state_q     <= StGap;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StGap: begin
          if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          gnt     <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: vector table for single/priority/stray-done flows,
// plus hand sequences for locked bursts, timeout and reset during a transaction.
module tb_rtc_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'd0, lock = 4'd0, we = 4'd0;
  logic [31:0] addr_in = 32'd0, data_in = 32'd0;
  logic [3:0]  gnt, ack;
  logic [7:0]  rdata, txn_addr, txn_data;
  logic        txn_start, txn_rd, busy, timeout_err;
  logic        txn_done = 1'b0;
  logic [7:0]  txn_rdata = 8'd0;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  rtc_bus_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr_in(addr_in), .data_in(data_in), .gnt(gnt), .ack(ack), .rdata(rdata),
    .txn_start(txn_start), .txn_rd(txn_rd), .txn_addr(txn_addr), .txn_data(txn_data),
    .txn_done(txn_done), .txn_rdata(txn_rdata), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [7:0] rdata;
    logic       start;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic       busy;
    logic       terr;
  } out_t;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic [7:0]  trd;
    int          n;
    out_t        exp;
  } vec_t;

  localparam logic [31:0] AR = 32'h2100_0000;
  localparam logic [31:0] AP = 32'h2100_4100;
  localparam logic [31:0] DP = 32'h0000_1500;

  vec_t vecs [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t got;
    got = '{gnt, ack, rdata, txn_start, txn_rd, txn_addr, txn_data, busy, timeout_err};
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (gnt,ack,rdata,start,rd,addr,data,busy,terr)",
               name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!$onehot0(gnt) || !$onehot0(ack) || (|ack && timeout_err)) begin
      nfail++;
      $display("FAIL invariant: gnt=%b ack=%b timeout_err=%b", gnt, ack, timeout_err);
    end
  end

  initial begin
    logic [3:0] exp_g;
    logic [3:0] got_g;
    int         c;
    int         k;
    logic       saw_ack;

    //            req   lock  we    addr data  done trd    n  {gnt ack rdata st rd addr data busy terr}
    vecs[0]  = '{4'h8, 4'h0, 4'h0, AR, 32'h0, 1'b0, 8'h00, 1, '{4'h8, 4'h0, 8'h00, 1'b1, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0}};
    vecs[1]  = '{4'h8, 4'h0, 4'h0, AR, 32'h0, 1'b0, 8'h00, 9, '{4'h8, 4'h0, 8'h00, 1'b0, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0}};
    vecs[2]  = '{4'h8, 4'h0, 4'h0, AR, 32'h0, 1'b1, 8'h37, 1, '{4'h0, 4'h8, 8'h37, 1'b0, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0}};
    vecs[3]  = '{4'h0, 4'h0, 4'h0, AR, 32'h0, 1'b0, 8'h00, 1, '{4'h0, 4'h0, 8'h37, 1'b0, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0}};
    vecs[4]  = '{4'h0, 4'h0, 4'h0, AR, 32'h0, 1'b0, 8'h00, 1, '{4'h0, 4'h0, 8'h37, 1'b0, 1'b1, 8'h21, 8'h00, 1'b0, 1'b0}};
    vecs[5]  = '{4'hA, 4'h0, 4'h2, AP, DP,    1'b0, 8'h00, 1, '{4'h2, 4'h0, 8'h37, 1'b1, 1'b0, 8'h41, 8'h15, 1'b1, 1'b0}};
    vecs[6]  = '{4'hA, 4'h0, 4'h2, AP, DP,    1'b0, 8'h00, 3, '{4'h2, 4'h0, 8'h37, 1'b0, 1'b0, 8'h41, 8'h15, 1'b1, 1'b0}};
    vecs[7]  = '{4'hA, 4'h0, 4'h2, AP, DP,    1'b1, 8'hAA, 1, '{4'h0, 4'h2, 8'h37, 1'b0, 1'b0, 8'h41, 8'h15, 1'b1, 1'b0}};
    vecs[8]  = '{4'h8, 4'h0, 4'h2, AP, DP,    1'b0, 8'h00, 1, '{4'h0, 4'h0, 8'h37, 1'b0, 1'b0, 8'h41, 8'h15, 1'b1, 1'b0}};
    vecs[9]  = '{4'h8, 4'h0, 4'h2, AP, DP,    1'b0, 8'h00, 1, '{4'h0, 4'h0, 8'h37, 1'b0, 1'b0, 8'h41, 8'h15, 1'b0, 1'b0}};
    vecs[10] = '{4'h8, 4'h0, 4'h2, AP, DP,    1'b0, 8'h00, 1, '{4'h8, 4'h0, 8'h37, 1'b1, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0}};
    vecs[11] = '{4'h8, 4'h0, 4'h2, AP, DP,    1'b1, 8'h5A, 1, '{4'h0, 4'h8, 8'h5A, 1'b0, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0}};
    vecs[12] = '{4'h0, 4'h0, 4'h0, AR, 32'h0, 1'b0, 8'h00, 1, '{4'h0, 4'h0, 8'h5A, 1'b0, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0}};
    vecs[13] = '{4'h0, 4'h0, 4'h0, AR, 32'h0, 1'b0, 8'h00, 1, '{4'h0, 4'h0, 8'h5A, 1'b0, 1'b1, 8'h21, 8'h00, 1'b0, 1'b0}};
    vecs[14] = '{4'h0, 4'h0, 4'h0, AR, 32'h0, 1'b1, 8'hFF, 1, '{4'h0, 4'h0, 8'h5A, 1'b0, 1'b1, 8'h21, 8'h00, 1'b0, 1'b0}};
    vecs[15] = '{4'h8, 4'h0, 4'h0, AR, 32'h0, 1'b0, 8'h00, 1, '{4'h8, 4'h0, 8'h5A, 1'b1, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0}};
    vecs[16] = '{4'h8, 4'h0, 4'h0, AR, 32'h0, 1'b1, 8'h11, 1, '{4'h0, 4'h8, 8'h11, 1'b0, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0}};
    vecs[17] = '{4'h0, 4'h0, 4'h0, AR, 32'h0, 1'b1, 8'hEE, 1, '{4'h0, 4'h0, 8'h11, 1'b0, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0}};
    vecs[18] = '{4'h0, 4'h0, 4'h0, AR, 32'h0, 1'b0, 8'h00, 1, '{4'h0, 4'h0, 8'h11, 1'b0, 1'b1, 8'h21, 8'h00, 1'b0, 1'b0}};

    step();
    check("reset_state", '{4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
    reset = 1'b0;
    step();
    check("idle_after_reset", '{4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      req       = vecs[i].req;
      lock      = vecs[i].lock;
      we        = vecs[i].we;
      addr_in   = vecs[i].addr;
      data_in   = vecs[i].data;
      txn_done  = vecs[i].done;
      txn_rdata = vecs[i].trd;
      for (int r = 0; r < vecs[i].n; r++) begin
        step();
        check($sformatf("vec%0d.%0d", i, r), vecs[i].exp);
      end
    end
    txn_done = 1'b0;

    // Locked burst: index 0 holds lock with index 3 also pending.
    req     = 4'b1001;
    lock    = 4'b0001;
    we      = 4'b0000;
    addr_in = 32'h3000_0010;
    for (int g = 0; g < 18; g++) begin
      exp_g = (g == 16) ? 4'b1000 : 4'b0001;
      c = 0;
      do begin
        step();
        c++;
      end while (!txn_start && c < 20);
      got_g = gnt;
      check_val($sformatf("burst_gnt%0d", g), int'(got_g), int'(exp_g));
      step();
      step();
      txn_done  = 1'b1;
      txn_rdata = 8'(g);
      step();
      txn_done = 1'b0;
      check_val($sformatf("burst_ack%0d", g), int'(ack), int'(exp_g));
    end
    req  = 4'd0;
    lock = 4'd0;
    repeat (3) step();

    // Timeout on a write: no done ever arrives.
    req     = 4'b0010;
    we      = 4'b0010;
    addr_in = 32'h0000_4200;
    data_in = 32'h0000_9900;
    step();
    check("to_issue", '{4'h2, 4'h0, 8'h11, 1'b1, 1'b0, 8'h42, 8'h99, 1'b1, 1'b0});
    req = 4'd0;
    k = 0;
    saw_ack = 1'b0;
    while (k < 200 && !timeout_err) begin
      step();
      k++;
      if (|ack) saw_ack = 1'b1;
    end
    check_val("to_latency", k, 127);
    check_val("to_no_ack", int'(saw_ack), 0);
    check("to_pulse", '{4'h0, 4'h0, 8'h11, 1'b0, 1'b0, 8'h42, 8'h99, 1'b1, 1'b1});
    step();
    check("to_gap", '{4'h0, 4'h0, 8'h11, 1'b0, 1'b0, 8'h42, 8'h99, 1'b1, 1'b0});
    step();
    check("to_idle", '{4'h0, 4'h0, 8'h11, 1'b0, 1'b0, 8'h42, 8'h99, 1'b0, 1'b0});

    // Reset in the middle of a read transaction.
    req     = 4'b1000;
    we      = 4'b0000;
    addr_in = AR;
    step();
    check("rst_issue", '{4'h8, 4'h0, 8'h11, 1'b1, 1'b1, 8'h21, 8'h00, 1'b1, 1'b0});
    repeat (3) step();
    #2 reset = 1'b1;
    #1 check("rst_async", '{4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
    #1 reset = 1'b0;
    req = 4'd0;
    txn_done  = 1'b1;
    txn_rdata = 8'h66;
    for (int r = 0; r < 4; r++) begin
      step();
      txn_done = 1'b0;
      check($sformatf("rst_quiet%0d", r), '{4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
